pwm_duty_ramp: RTL and testbench

//  Upstream duty sequencer for the PWM block. Drives its activeTime input with a

---
 rtl/pwm_duty_ramp.sv | 145 ++++++++++++++
 tb/tb_pwm_duty_ramp.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/pwm_duty_ramp.sv
// Duty sequencer for the PWM block: ramps or breathes activeTime toward a commanded target,
// updating only at PWM period boundaries so every period sees one consistent duty value.
module pwm_duty_ramp #(
  parameter int PRECISION_BITS = 8,
  parameter int PRESCALE_BITS  = 8
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      EN,
  input  logic                      cmdValid,
  output logic                      cmdReady,
  input  logic [PRECISION_BITS-1:0] cmdTarget,
  input  logic [PRECISION_BITS-1:0] cmdStep,
  input  logic [PRESCALE_BITS-1:0]  cmdPrescale,
  input  logic                      cmdBreathe,
  output logic [PRECISION_BITS-1:0] activeTime,
  output logic                      busy,
  output logic                      done
);

  localparam int P  = PRECISION_BITS;
  localparam int PS = PRESCALE_BITS;
  localparam logic [P-1:0]  PHASE_MAX = {P{1'b1}};
  localparam logic [P-1:0]  P_ZERO    = {P{1'b0}};
  localparam logic [P-1:0]  P_ONE     = {{(P-1){1'b0}}, 1'b1};
  localparam logic [PS-1:0] PS_ZERO   = {PS{1'b0}};
  localparam logic [PS-1:0] PS_ONE    = {{(PS-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RAMP    = 2'd1,
    BR_UP   = 2'd2,
    BR_DOWN = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [P-1:0]  phase_q, phase_d;
  logic [PS-1:0] presc_q, presc_d;
  logic [P-1:0]  active_q, active_d;
  logic          done_q, done_d;
  logic [P-1:0]  target_q, target_d;
  logic [P-1:0]  step_q, step_d;
  logic [PS-1:0] prescale_q, prescale_d;

  logic          accept_s;
  logic          period_end_s;
  logic [P-1:0]  goal_s;
  logic [P-1:0]  stepped_s;
  logic [P:0]    sum_s;
  logic [P:0]    diff_s;

  assign cmdReady     = (state_q != RAMP);
  assign busy         = (state_q != IDLE);
  assign done         = done_q;
  assign activeTime   = active_q;
  assign accept_s     = cmdValid && cmdReady;
  assign period_end_s = EN && (phase_q == PHASE_MAX);

  // Saturating one-step move of the duty toward the goal, computed one bit wider to avoid wrap
  always_comb begin
    goal_s    = (state_q == BR_DOWN) ? P_ZERO : target_q;
    sum_s     = {1'b0, active_q} + {1'b0, step_q};
    diff_s    = {1'b0, active_q} - {1'b0, goal_s};
    stepped_s = goal_s;
    if (step_q == P_ZERO) begin
      stepped_s = goal_s;
    end else if (active_q < goal_s) begin
      stepped_s = (sum_s >= {1'b0, goal_s}) ? goal_s : sum_s[P-1:0];
    end else begin
      stepped_s = (diff_s <= {1'b0, step_q}) ? goal_s : (active_q - step_q);
    end
  end

  // Next-state: command acceptance takes priority over a coincident step event
  always_comb begin
    state_d    = state_q;
    phase_d    = EN ? (phase_q + P_ONE) : phase_q;
    presc_d    = presc_q;
    active_d   = active_q;
    done_d     = 1'b0;
    target_d   = target_q;
    step_d     = step_q;
    prescale_d = prescale_q;
    if (accept_s) begin
      target_d   = cmdTarget;
      step_d     = cmdStep;
      prescale_d = cmdPrescale;
      presc_d    = PS_ZERO;
      if (cmdBreathe) begin
        state_d = BR_UP;
      end else if (cmdTarget == active_q) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end else begin
        state_d = RAMP;
      end
    end else if (period_end_s && (state_q != IDLE)) begin
      if (presc_q == prescale_q) begin
        presc_d  = PS_ZERO;
        active_d = stepped_s;
        if (stepped_s == goal_s) begin
          case (state_q)
            RAMP: begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
            BR_UP:   state_d = BR_DOWN;
            BR_DOWN: state_d = BR_UP;
            default: state_d = IDLE;
          endcase
        end else begin
          state_d = state_q;
        end
      end else begin
        presc_d = presc_q + PS_ONE;
      end
    end else begin
      state_d = state_q;
    end
  end

  // State and datapath registers, cleared asynchronously by RST
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= IDLE;
      phase_q    <= P_ZERO;
      presc_q    <= PS_ZERO;
      active_q   <= P_ZERO;
      done_q     <= 1'b0;
      target_q   <= P_ZERO;
      step_q     <= P_ZERO;
      prescale_q <= PS_ZERO;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      presc_q    <= presc_d;
      active_q   <= active_d;
      done_q     <= done_d;
      target_q   <= target_d;
      step_q     <= step_d;
      prescale_q <= prescale_d;
    end
  end

endmodule

// File: tb/tb_pwm_duty_ramp.sv
// Bench for pwm_duty_ramp: directed and randomized commands checked per period against an
// integer model of the ramp/breathe rules; the bench keeps its own count of the PWM phase.
module tb_pwm_duty_ramp;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       EN = 1'b0;
  logic       cmdValid = 1'b0;
  logic       cmdBreathe = 1'b0;
  logic [7:0] cmdTarget = 8'd0;
  logic [7:0] cmdStep = 8'd0;
  logic [7:0] cmdPrescale = 8'd0;
  logic       cmdReady, busy, done;
  logic [7:0] activeTime;

  int errors = 0;
  int checks = 0;
  int ph = 0;
  int done_cnt = 0;
  int duty = 0;

  pwm_duty_ramp #(.PRECISION_BITS(8), .PRESCALE_BITS(8)) dut (
    .CLK(CLK), .RST(RST), .EN(EN), .cmdValid(cmdValid), .cmdReady(cmdReady),
    .cmdTarget(cmdTarget), .cmdStep(cmdStep), .cmdPrescale(cmdPrescale),
    .cmdBreathe(cmdBreathe), .activeTime(activeTime), .busy(busy), .done(done)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock; the bench's phase follows the period definition (EN cycles, mod 256)
  task automatic tick();
    @(posedge CLK);
    if (RST) ph = 0;
    else if (EN) ph = (ph + 1) % 256;
    #1;
    if (done === 1'b1) done_cnt++;
  endtask

  task automatic to_period_end();
    do tick(); while (ph != 0);
  endtask

  function automatic int model_step(input int cur, input int goal, input int stp);
    if (stp == 0) return goal;
    if (cur < goal) return (cur + stp >= goal) ? goal : cur + stp;
    return (cur - goal <= stp) ? goal : cur - stp;
  endfunction

  task automatic send(input int tgt, input int stp, input int psc, input bit br);
    check("ready_before_cmd", cmdReady, 1);
    cmdTarget = tgt[7:0]; cmdStep = stp[7:0]; cmdPrescale = psc[7:0]; cmdBreathe = br;
    cmdValid = 1'b1;
    tick();
    cmdValid = 1'b0;
    cmdTarget = $urandom; cmdStep = $urandom; cmdPrescale = $urandom; cmdBreathe = $urandom;
  endtask

  task automatic ramp(input int tgt, input int stp, input int psc, input string tag);
    int d0 = done_cnt;
    int k = 0;
    send(tgt, stp, psc, 1'b0);
    if (tgt == duty) begin
      check({tag, "_eq_done"}, done, 1);
      check({tag, "_eq_busy"}, busy, 0);
    end else begin
      check({tag, "_busy"}, busy, 1);
      check({tag, "_ready_low"}, cmdReady, 0);
      while (duty != tgt) begin
        to_period_end();
        k++;
        if (k % (psc + 1) == 0) duty = model_step(duty, tgt, stp);
        check({tag, "_val"}, activeTime, duty);
        if (duty != tgt) begin
          check({tag, "_ready_mid"}, cmdReady, 0);
          cmdValid = 1'b1;
          cmdTarget = $urandom;
          tick();
          cmdValid = 1'b0;
        end else begin
          check({tag, "_done_at_goal"}, done, 1);
        end
      end
      tick();
      check({tag, "_idle_busy"}, busy, 0);
      check({tag, "_idle_ready"}, cmdReady, 1);
    end
    check({tag, "_done_count"}, done_cnt - d0, 1);
  endtask

  task automatic breathe(input int tgt, input int stp, input int nper, input string tag);
    int d0 = done_cnt;
    bit up = 1'b1;
    int goal;
    send(tgt, stp, 0, 1'b1);
    check({tag, "_busy"}, busy, 1);
    repeat (nper) begin
      to_period_end();
      goal = up ? tgt : 0;
      duty = model_step(duty, goal, stp);
      if (duty == goal) up = ~up;
      check({tag, "_val"}, activeTime, duty);
      check({tag, "_ready"}, cmdReady, 1);
    end
    check({tag, "_no_done"}, done_cnt - d0, 0);
  endtask

  initial begin
    int d0;
    int tgt, stp, psc;
    repeat (3) tick();
    RST = 1'b0;
    check("rst_active", activeTime, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", cmdReady, 1);
    check("rst_done", done, 0);
    EN = 1'b1;

    ramp(0, 3, 0, "eq_at_zero");
    ramp(10, 4, 0, "up_10_s4");
    ramp(0, 7, 1, "down_0_s7_p1");
    ramp(250, 0, 0, "jump_250");
    ramp(255, 200, 0, "sat_255");
    ramp(5, 0, 0, "jump_5");
    ramp(0, 0, 0, "jump_0");

    breathe(6, 3, 6, "br_6_3");
    breathe(9, 4, 6, "br_restart");
    ramp(0, 0, 0, "br_exit");

    // Freeze mid-ramp with EN low, then resume at the same phase
    d0 = done_cnt;
    send(200, 10, 0, 1'b0);
    to_period_end();
    duty = model_step(duty, 200, 10);
    check("frz_first", activeTime, duty);
    repeat (100) tick();
    EN = 1'b0;
    repeat (1000) tick();
    check("frz_hold", activeTime, duty);
    check("frz_busy", busy, 1);
    EN = 1'b1;
    to_period_end();
    duty = model_step(duty, 200, 10);
    check("frz_resume", activeTime, duty);

    // Asynchronous reset in the middle of the ramp
    repeat (50) tick();
    RST = 1'b1;
    #1;
    check("rst_mid_active", activeTime, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_ready", cmdReady, 1);
    check("rst_mid_done", done, 0);
    repeat (3) tick();
    RST = 1'b0;
    duty = 0;
    check("frz_rst_no_done", done_cnt - d0, 0);
    ramp(0, 9, 0, "eq_after_rst");

    for (int i = 0; i < 4; i++) begin
      tgt = $urandom_range(0, 255);
      stp = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(16, 255);
      psc = $urandom_range(0, 1);
      ramp(tgt, stp, psc, "rand_ramp");
    end
    tgt = $urandom_range(1, 255);
    breathe(tgt, $urandom_range(32, 255), 8, "rand_br");
    ramp(duty, 5, 0, "rand_br_exit");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
